// File: rtl/noise_sequencer.sv
// noise_sequencer
// Step sequencer that fires per-channel noise bursts from a programmable
// CH x STEPS pattern, paced by an external beat_tick. A 16-bit Fibonacci
// LFSR supplies the noise; each channel's bit is gated by its burst.
// Ports:
//   clk, rst                    sole clock; synchronous active-high reset
//   start, stop, pause          single-cycle control pulses (stop > start > pause)
//   beat_tick                   one pulse per beat, counted only in RUN
//   loop_en                     1 = wrap after the last step, 0 = one-shot
//   wr_en/wr_ch/wr_step/wr_bit  pattern write port, usable in any state
//   is_noise                    per-channel burst active
//   noise_bit                   lfsr[c] AND is_noise[c]
//   step_idx, state, done       current step, FSM state, one-shot end pulse
//
// state | meaning
// IDLE  | stopped; beat_tick ignored, LFSR held
// RUN   | counting beats, loading/decrementing bursts, LFSR stepping
// PAUSE | counters, bursts, LFSR and outputs frozen until next pause
module noise_sequencer #(
  parameter int          CH             = 2,
  parameter int          STEPS          = 16,
  parameter int          BEATS_PER_STEP = 4,
  parameter int          BURST_BEATS    = 4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  localparam int         CH_W           = (CH > 1) ? $clog2(CH) : 1,
  localparam int         STEP_W         = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              beat_tick,
  input  logic              loop_en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [STEP_W-1:0] wr_step,
  input  logic              wr_bit,
  output logic [CH-1:0]     is_noise,
  output logic [CH-1:0]     noise_bit,
  output logic [STEP_W-1:0] step_idx,
  output logic [1:0]        state,
  output logic              done
);

  localparam int BEAT_W  = (BEATS_PER_STEP > 1) ? $clog2(BEATS_PER_STEP) : 1;
  localparam int BURST_W = $clog2(BURST_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [BURST_W-1:0]  burst_q [CH];
  logic [BURST_W-1:0]  burst_d [CH];
  logic [STEPS-1:0]    pattern [CH];
  logic [CH-1:0]       is_noise_q;
  logic [15:0]         lfsr_q;
  logic                done_q;

  logic                do_start, do_stop, do_tick, step_end, last_end, enter;
  logic [STEP_W-1:0]   enter_step;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_start = 1'b0;
    do_stop  = 1'b0;
    do_tick  = 1'b0;
    step_end = 1'b0;
    last_end = 1'b0;
    if (stop) begin
      state_d = IDLE;
      do_stop = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d  = RUN;
          do_start = 1'b1;
        end
        RUN: begin
          // A pause pulse freezes this cycle too, so a coincident tick is dropped.
          if (pause) begin
            state_d = PAUSE;
          end else if (beat_tick) begin
            do_tick = 1'b1;
            if (beat_q == BEAT_W'(BEATS_PER_STEP - 1)) begin
              step_end = 1'b1;
              if (step_q == STEP_W'(STEPS - 1) && !loop_en) begin
                state_d  = IDLE;
                last_end = 1'b1;
              end
            end
          end
        end
        PAUSE: if (pause) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Step entry: start enters step 0; a step end enters the next step, which
  // wraps to 0 naturally because STEPS is a power of two.
  assign enter      = do_start | (step_end & ~last_end);
  assign enter_step = do_start ? '0 : step_q + STEP_W'(1);

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      burst_d[c] = burst_q[c];
      if (do_stop)
        burst_d[c] = '0;
      else if (enter && pattern[c][enter_step])
        burst_d[c] = BURST_W'(BURST_BEATS);
      else if (do_tick && burst_q[c] != '0)
        burst_d[c] = burst_q[c] - BURST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q     <= '0;
      beat_q     <= '0;
      is_noise_q <= '0;
      lfsr_q     <= LFSR_SEED;
      done_q     <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        burst_q[c] <= '0;
        pattern[c] <= '0;
      end
    end else begin
      if (wr_en && (int'(wr_ch) < CH)) pattern[wr_ch][wr_step] <= wr_bit;
      done_q <= last_end;
      if (state_q == RUN)
        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (do_stop || do_start) begin
        step_q <= '0;
        beat_q <= '0;
      end else if (do_tick) begin
        if (step_end) begin
          beat_q <= '0;
          step_q <= last_end ? '0 : step_q + STEP_W'(1);
        end else begin
          beat_q <= beat_q + BEAT_W'(1);
        end
      end
      for (int c = 0; c < CH; c++) begin
        burst_q[c]    <= burst_d[c];
        is_noise_q[c] <= (burst_d[c] != '0);
      end
    end
  end

  assign is_noise  = is_noise_q;
  assign noise_bit = lfsr_q[CH-1:0] & is_noise_q;
  assign step_idx  = step_q;
  assign state     = state_q;
  assign done      = done_q;

endmodule

// File: doc/noise_sequencer.md
NOISE_SEQUENCER -- requirements
Module: noise_sequencer

Interface
REQ-001 SHALL have parameter CH, default 2: number of noise channels (1..16).
REQ-002 SHALL have parameter STEPS, default 16: pattern steps per channel (power of 2, ≥2).
REQ-003 SHALL have parameter BEATS_PER_STEP, default 4: beat_tick pulses per step (≥1).
REQ-004 SHALL have parameter BURST_BEATS, default 4: beats is_noise stays high after a trigger (≥1).
REQ-005 SHALL have parameter LFSR_SEED, default 16'hACE1: LFSR reset value (nonzero).
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports start, stop, pause  in  1 each  single-cycle control pulses.
REQ-009 SHALL have port beat_tick  in  1  one-cycle pulse per beat.
REQ-010 SHALL have port loop_en  in  1  1 = wrap after last step; 0 = one-shot.
REQ-011 SHALL have ports wr_en in 1, wr_ch in clog2(CH) (min 1), wr_step in clog2(STEPS), wr_bit in 1: pattern write port.
REQ-012 SHALL have port is_noise  out  CH  per-channel burst active.
REQ-013 SHALL have port noise_bit  out  CH  lfsr[c] AND is_noise[c].
REQ-014 SHALL have ports step_idx out clog2(STEPS); state out 2 (00 IDLE, 01 RUN, 10 PAUSE); done out 1.

Function
REQ-015 SHALL hold a CH×STEPS-bit pattern; wr_en writes pattern[wr_ch][wr_step]=wr_bit next edge in any state; a write to the current step takes effect only at next entry of that step; out-of-range wr_ch ignored.
REQ-016 SHALL implement FSM: IDLE -start-> RUN; RUN -pause-> PAUSE; PAUSE -pause-> RUN; any -stop-> IDLE; RUN -end of last step, loop_en=0-> IDLE.
REQ-017 SHALL apply control priority rst > stop > start > pause; start in RUN/PAUSE and pause in IDLE ignored.
REQ-018 SHALL, on IDLE->RUN, set step_idx=0, beat counter=0, and perform step entry for step 0.
REQ-019 SHALL, in RUN on beat_tick, increment beat counter; when it was BEATS_PER_STEP-1, clear it and advance step_idx, performing step entry for the new step.
REQ-020 SHALL, at step STEPS-1 end: loop_en=1 -> step_idx=0 with step entry, no done; loop_en=0 -> IDLE, step_idx=0, one-cycle done=1.
REQ-021 SHALL, on step entry, for each channel c with pattern[c][step]=1, load burst[c]=BURST_BEATS (retrigger reloads an active burst); unset channels keep counting.
REQ-022 SHALL decrement nonzero burst[c] on each RUN beat_tick not coinciding with a reload of c; is_noise[c] = (burst[c]!=0), registered, high the cycle after step entry.
REQ-023 SHALL advance a 16-bit Fibonacci LFSR (taps 16,14,13,11) every clock in RUN only; noise_bit[c] uses lfsr[c].
REQ-024 SHALL freeze counters, bursts, LFSR, and outputs in PAUSE; beat_tick ignored in IDLE/PAUSE.
REQ-025 SHALL, on stop, clear step_idx, beat counter, all bursts, is_noise, noise_bit; LFSR and pattern retained; no done.
REQ-026 SHALL ignore beat_tick coinciding with start (start cycle is beat 0 of step 0).
REQ-027 SHALL, with CH=1, pattern bits at steps 4 and 12, defaults otherwise, assert is_noise exactly during global beats 16–19 and 48–51.

Reset
REQ-028 SHALL, on rst, set state=IDLE, step_idx=0, beat counter=0, bursts=0, is_noise=0, noise_bit=0, done=0, lfsr=LFSR_SEED, pattern all zeros.
REQ-029 SHALL, on rst mid-RUN, reach reset values next edge regardless of other inputs.

Verification
REQ-030 Legacy: CH=1, write steps 4,12, start, loop_en=0, 64 beat_ticks -> is_noise high beats 16–19, 48–51 only; done pulse after tick 64; state=IDLE.
REQ-031 Loop/retrigger: BURST_BEATS=6, ch0 steps 0,1, loop_en=1 -> is_noise[0] high continuously beats 0–9, low 10; after tick 64 step_idx=0, burst reloaded, no done.
REQ-032 Pause: pause at beat 17 for 20 cycles with ticks -> step_idx, is_noise, noise_bit, lfsr unchanged; resume completes burst at beat 19 as normal.
REQ-033 Stop/priority: stop+start same cycle in RUN -> IDLE, is_noise=0, step_idx=0, done=0; start+beat_tick -> beat counter 0.
REQ-034 Write hazard: write current step's bit mid-step -> no effect until step re-entered on next loop.
REQ-035 LFSR: 10 RUN cycles from reset -> lfsr equals 10th successor of 16'hACE1; noise_bit=0 wherever is_noise=0.
